// File: rtl/analog_if_pkg.sv
// Shared definitions for the analog_wrapper driver/checker: FSM encoding and default sizing.
package analog_if_pkg;

    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefSettleW    = 8;
    localparam int unsigned DefCntW       = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with synchronous active-high reset.
module sync_bit #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/analog_if_ctrl.sv
// Drives the analog macro inputs, waits a settle time, samples the synchronised
// macro output and checks it against in1 & in2, keeping saturating pass/fail counts.
module analog_if_ctrl
    import analog_if_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned SETTLE_W    = DefSettleW,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    input  logic                in1_val_i,
    input  logic                in2_val_i,
    input  logic [SETTLE_W-1:0] settle_cycles_i,
    input  logic                clear_cnt_i,
    output logic                ana_in1_o,
    output logic                ana_in2_o,
    input  logic                ana_out_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                result_o,
    output logic                match_o,
    output logic [CNT_W-1:0]    pass_cnt_o,
    output logic [CNT_W-1:0]    fail_cnt_o
);

    // Two extra bits so settle_cycles_i + SYNC_STAGES never wraps.
    localparam int unsigned CntW = SETTLE_W + 2;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              in1_q, in1_d;
    logic              in2_q, in2_d;
    logic              exp_q, exp_d;
    logic              result_q, result_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  fail_q, fail_d;
    logic              ana_sync;
    logic [CntW-1:0]   settle_load;

    sync_bit #(
        .Stages(SYNC_STAGES)
    ) u_sync (
        .clk_i(wb_clk_i),
        .rst_i(wb_rst_i),
        .d_i  (ana_out_i),
        .q_o  (ana_sync)
    );

    assign settle_load = CntW'(settle_cycles_i) + CntW'(SYNC_STAGES);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        exp_d    = exp_q;
        result_d = result_q;
        match_d  = match_q;
        pass_d   = pass_q;
        fail_d   = fail_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    in1_d   = in1_val_i;
                    in2_d   = in2_val_i;
                    exp_d   = in1_val_i & in2_val_i;
                    cnt_d   = settle_load;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StSample;
                end
            end
            StSample: begin
                result_d = ana_sync;
                match_d  = (ana_sync == exp_q);
                if (ana_sync == exp_q) begin
                    if (pass_q != {CNT_W{1'b1}}) pass_d = pass_q + CNT_W'(1);
                end else begin
                    if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + CNT_W'(1);
                end
                state_d = StDone;
            end
            StDone: begin
                in1_d   = 1'b0;
                in2_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Clear takes priority over a same-edge sample update.
        if (clear_cnt_i) begin
            pass_d = '0;
            fail_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            exp_q    <= 1'b0;
            result_q <= 1'b0;
            match_q  <= 1'b0;
            pass_q   <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            match_q  <= match_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign ana_in1_o  = in1_q;
    assign ana_in2_o  = in2_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign result_o   = result_q;
    assign match_o    = match_q;
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;

endmodule

// File: tb/tb_analog_if_ctrl.sv
// Scoreboard bench for analog_if_ctrl: a behavioural AND macro model, a default
// instance and a CNT_W=2 instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_analog_if_ctrl;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst, start, in1v, in2v, clr;
    logic [7:0] settle;
    logic       ana_out;

    logic        a_in1, a_in2, a_busy, a_done, a_res, a_match;
    logic [15:0] a_pass, a_fail;
    logic        b_in1, b_in2, b_busy, b_done, b_res, b_match;
    logic [1:0]  b_pass, b_fail;

    logic model_stuck = 1'b0;
    logic ovr_en      = 1'b0;
    logic ovr_val     = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int   e_done;
        logic res;
        logic mt;
        int   pass;
        int   fail;
        int   pass2;
        int   fail2;
    } exp_t;

    exp_t sb_q[$];
    int   m_pass = 0, m_fail = 0, m_pass2 = 0, m_fail2 = 0;

    logic cur_valid = 1'b0;
    int   cur_e0, cur_edone;
    logic cur_in1, cur_in2;
    int   mon_k;
    logic mon_busy;
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural macro: out = in1 & in2, with stuck-at-0 and override hooks.
    always_comb ana_out = ovr_en ? ovr_val : (!model_stuck & a_in1 & a_in2);

    analog_if_ctrl dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .start_i        (start),
        .in1_val_i      (in1v),
        .in2_val_i      (in2v),
        .settle_cycles_i(settle),
        .clear_cnt_i    (clr),
        .ana_in1_o      (a_in1),
        .ana_in2_o      (a_in2),
        .ana_out_i      (ana_out),
        .busy_o         (a_busy),
        .done_o         (a_done),
        .result_o       (a_res),
        .match_o        (a_match),
        .pass_cnt_o     (a_pass),
        .fail_cnt_o     (a_fail)
    );

    analog_if_ctrl #(
        .CNT_W(2)
    ) dut_sat (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .start_i        (start),
        .in1_val_i      (in1v),
        .in2_val_i      (in2v),
        .settle_cycles_i(settle),
        .clear_cnt_i    (clr),
        .ana_in1_o      (b_in1),
        .ana_in2_o      (b_in2),
        .ana_out_i      (ana_out),
        .busy_o         (b_busy),
        .done_o         (b_done),
        .result_o       (b_res),
        .match_o        (b_match),
        .pass_cnt_o     (b_pass),
        .fail_cnt_o     (b_fail)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compare each done pulse against the head of the scoreboard; track busy/drive levels.
    always @(negedge clk) begin
        mon_k = edge_cnt - 1;
        if (!rst) begin
            if (a_done) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("done_edge", mon_k, mon_e.e_done);
                    check_eq("res_known", {31'd0, $isunknown(a_res)}, 32'd0);
                    check_eq("result", a_res, mon_e.res);
                    check_eq("match", a_match, mon_e.mt);
                    check_eq("pass_cnt", a_pass, mon_e.pass);
                    check_eq("fail_cnt", a_fail, mon_e.fail);
                    check_eq("sat_done", b_done, 1'b1);
                    check_eq("sat_pass_cnt", b_pass, mon_e.pass2);
                    check_eq("sat_fail_cnt", b_fail, mon_e.fail2);
                end
            end
            if (cur_valid && mon_k >= cur_e0 && mon_k <= cur_edone + 1) begin
                mon_busy = (mon_k <= cur_edone);
                check_eq("busy", a_busy, mon_busy);
                check_eq("ana_in1", a_in1, mon_busy & cur_in1);
                check_eq("ana_in2", a_in2, mon_busy & cur_in2);
            end
        end
    end

    task automatic run_one(input logic i1, input logic i2, input int s, input logic stuck,
                           input logic clr_sample, input logic busy_pulse,
                           input logic toggle, input logic tog_val);
        exp_t e;
        int   e0;
        bit   seen;
        @(negedge clk);
        model_stuck = stuck;
        start       = 1'b1;
        in1v        = i1;
        in2v        = i2;
        settle      = 8'(s);
        @(posedge clk);
        e0        = edge_cnt;
        cur_e0    = e0;
        cur_edone = e0 + s + N + 2;
        cur_in1   = i1;
        cur_in2   = i2;
        cur_valid = 1'b1;
        e.e_done  = e0 + s + N + 2;
        e.res     = toggle ? tog_val : (stuck ? 1'b0 : (i1 & i2));
        e.mt      = (e.res == (i1 & i2));
        if (clr_sample) begin
            m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
        end else if (e.mt) begin
            if (m_pass < 65535) m_pass++;
            if (m_pass2 < 3) m_pass2++;
        end else begin
            if (m_fail < 65535) m_fail++;
            if (m_fail2 < 3) m_fail2++;
        end
        e.pass = m_pass; e.fail = m_fail; e.pass2 = m_pass2; e.fail2 = m_fail2;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (busy_pulse) begin
            @(negedge clk);
            start = 1'b1; in1v = ~i1; in2v = ~i2; settle = 8'd0;
            @(negedge clk);
            start = 1'b0;
        end
        if (toggle) begin
            ovr_en = 1'b1; ovr_val = 1'b0;
            #2.3 ovr_val = 1'b1;
            #3.1 ovr_val = 1'b0;
            #2.7 ovr_val = 1'b1;
            #4.4 ovr_val = 1'b0;
            #1.9 ovr_val = tog_val;
        end
        if (clr_sample) begin
            while (edge_cnt != e0 + s + N + 2) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
        ovr_en      = 1'b0;
        model_stuck = 1'b0;
    endtask

    initial begin
        logic [1:0] v;
        rst = 1'b1; start = 1'b0; in1v = 1'b0; in2v = 1'b0; clr = 1'b0; settle = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_ana_in1", a_in1, 1'b0);
        check_eq("rst_busy", a_busy, 1'b0);
        check_eq("rst_done", a_done, 1'b0);
        check_eq("rst_result", a_res, 1'b0);
        check_eq("rst_match", a_match, 1'b0);
        check_eq("rst_pass", a_pass, 16'd0);
        check_eq("rst_fail", a_fail, 16'd0);
        rst = 1'b0;

        // Abort a run mid-settle with reset.
        @(negedge clk);
        start = 1'b1; in1v = 1'b1; in2v = 1'b1; settle = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_pre_in1", a_in1, 1'b1);
        check_eq("abort_pre_busy", a_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_in1", a_in1, 1'b0);
        check_eq("abort_in2", a_in2, 1'b0);
        check_eq("abort_busy", a_busy, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("abort_pass", a_pass, 16'd0);
        check_eq("abort_fail", a_fail, 16'd0);

        run_one(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            run_one(v[1], v[0], 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_one(1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_one(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one(1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_one(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_one(1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_one(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("end_busy", a_busy, 1'b0);
        check_eq("end_ana_in1", a_in1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/analog_if_ctrl.md
Name: analog_if_ctrl

Overview:
- Digital-side driver/checker for the analog_wrapper macro.
- Drives the macro's two inputs with a requested pattern and waits a programmable settle time.
- Synchronises and samples the macro's asynchronous output, then compares it against the expected logical response (in1 & in2).
- Sits in the user project wrapper between the SoC control logic and the analog macro pins; keeps pass/fail statistics.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ana_out_i before sampling (>=2).
- SETTLE_W, 8, width of settle_cycles_i.
- CNT_W, 16, width of the pass and fail counters.

Ports:
- wb_clk_i  in  1  single system clock, all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to run a measurement; ignored unless IDLE.
- in1_val_i  in  1  level to drive on ana_in1_o; sampled with start_i.
- in2_val_i  in  1  level to drive on ana_in2_o; sampled with start_i.
- settle_cycles_i  in  SETTLE_W  extra wait cycles after drive; sampled with start_i.
- clear_cnt_i  in  1  synchronous clear of both counters.
- ana_in1_o  out  1  to analog_wrapper in1 (registered).
- ana_in2_o  out  1  to analog_wrapper in2 (registered).
- ana_out_i  in  1  from analog_wrapper out; asynchronous to wb_clk_i.
- busy_o  out  1  high while a measurement is in progress.
- done_o  out  1  one-cycle pulse: result_o/match_o valid.
- result_o  out  1  sampled synchronised macro output; held until next done.
- match_o  out  1  result_o == (in1 & in2) of that run; held until next done.
- pass_cnt_o  out  CNT_W  saturating count of matching runs.
- fail_cnt_o  out  CNT_W  saturating count of mismatching runs.

Behaviour:
- Reset (wb_rst_i high at an edge): state IDLE, all outputs 0, counters 0, sync chain 0, settle counter 0. Applies mid-operation: ana_in*_o drop to 0 at that edge; no done_o issued for the aborted run.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - on start_i at edge E0: latch in1/in2 into ana_in*_o and expected = in1_val_i & in2_val_i.
  - load cnt = settle_cycles_i + SYNC_STAGES (width SETTLE_W+2, no overflow); go SETTLE.
- SETTLE: at each edge, if cnt != 0 then decrement, else go SAMPLE.
- SAMPLE: at the edge, capture the last sync stage into result_o, set match_o, update counters, go DONE.
- DONE: done_o = 1 for this one cycle; at the next edge go IDLE and drive ana_in*_o to 0.
- Latency, with S = settle_cycles_i and N = SYNC_STAGES:
  - done_o is high in the cycle after edge E0+S+N+2.
  - busy_o is high from after E0 through the DONE cycle inclusive.
  - Back-to-back runs: a start_i on the cycle after DONE (IDLE) is accepted.
- start_i while busy_o = 1: ignored; no queueing; latched values unchanged.
- settle_cycles_i = 0: minimum wait of N+1 SETTLE cycles.
- Counters:
  - pass_cnt increments when match, fail_cnt when mismatch; each saturates at 2^CNT_W-1.
  - clear_cnt_i at the same edge as a SAMPLE update: clear wins, the counter ends at 0.
- The sync chain runs continuously in every state, including IDLE.
- No combinational path from any input to any output.

Decomposition:
- Shared package analog_if_pkg: FSM state encoding (2-bit localparams IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and default SYNC_STAGES/SETTLE_W/CNT_W constants.
- One sub-module, sync_bit: parameterised N-stage single-bit synchroniser with synchronous active-high reset, reusable elsewhere in the design.
- The top level holds the FSM, settle counter and statistics counters.

Test Plan:
- Reset mid-SETTLE (S=10, start, reset 3 cycles later) -> next cycle ana_in*_o=0, busy_o=0; no done_o within 20 cycles; counters remain 0.
- Basic run, N=2, S=3, in1=1, in2=1, behavioural AND model -> done_o at E0+7 only, result_o=1, match_o=1, pass_cnt=1; ana_in*_o=1 in cycles E0+1..E0+7, then 0.
- All four input combinations, S=0 -> result_o equals AND each run; pass_cnt=4, fail_cnt=0; each done_o at E0+4.
- Forced mismatch (model stuck at 0, in1=in2=1) -> match_o=0, fail_cnt increments; start_i pulsed during busy is ignored (exactly one done_o).
- CNT_W=2, 5 matching runs -> pass_cnt_o saturates at 3; clear_cnt_i coinciding with the SAMPLE edge -> pass_cnt_o=0 after that edge.
- ana_out_i toggled asynchronously mid-SETTLE with S=5 -> result_o reflects the value stable for at least N cycles before SAMPLE; no X propagation.
